// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: opcodes, FSM states, ALU/mux codes, trap causes.
// Also holds the per-state Moore control table so the FSM only decides transitions.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_MEM_TMO = 2'b10;

   typedef struct packed {
      logic       pcWriteCond;
      logic       memRead;
      logic       memWrite;
      logic       iOrD;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       memToReg;
      logic       regWrite;
   } ctrl_t;

   function automatic logic isLegal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   // Controls to present while sitting in state s for an instruction of class op.
   function automatic ctrl_t ctrlFor(input state_t s, input logic [6:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memRead = 1'b1;
            c.aluSrcB = SRCB_FOUR;
            c.aluOp   = ALU_ADD;
         end
         S_EXEC: begin
            c.aluSrcA = 1'b1;
            case (op)
               OP_R:      begin c.aluSrcB = SRCB_RS2; c.aluOp = ALU_FUNCT; end
               OP_IALU:   begin c.aluSrcB = SRCB_IMM; c.aluOp = ALU_FUNCT; end
               OP_BRANCH: begin c.aluSrcB = SRCB_RS2; c.aluOp = ALU_SUB; c.pcWriteCond = 1'b1; end
               default:   begin c.aluSrcB = SRCB_IMM; c.aluOp = ALU_ADD; end
            endcase
         end
         S_MEM: begin
            c.iOrD     = 1'b1;
            c.memRead  = (op == OP_LOAD);
            c.memWrite = (op == OP_STORE);
         end
         S_WB: begin
            c.regWrite = 1'b1;
            c.memToReg = (op == OP_LOAD);
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> IR/datapath/memory bundle; master = controller, slave = datapath side.
// Perf counter signals exist only with MULTICYCLE_CONTROL_PERF_EN defined.
interface multicycle_control_if #(
   parameter int OPCODE_W = 7
`ifdef MULTICYCLE_CONTROL_PERF_EN
   , parameter int CNT_W = 32
`endif
);
   logic                run;
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;
   logic                pc_write;
   logic                pc_write_cond;
   logic                ir_write;
   logic                mem_read;
   logic                mem_write;
   logic                i_or_d;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          alu_op;
   logic                mem_to_reg;
   logic                reg_write;
   logic [2:0]          state_o;
   logic                trap;
   logic [1:0]          trap_cause;
`ifdef MULTICYCLE_CONTROL_PERF_EN
   logic [CNT_W-1:0]    perf_cycles;
   logic [CNT_W-1:0]    perf_instret;
`endif

   modport master (
      input  run, opcode, mem_ready,
      output pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
             alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
             state_o, trap, trap_cause
`ifdef MULTICYCLE_CONTROL_PERF_EN
      , output perf_cycles, perf_instret
`endif
   );

   modport slave (
      output run, opcode, mem_ready,
      input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
             alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
             state_o, trap, trap_cause
`ifdef MULTICYCLE_CONTROL_PERF_EN
      , input perf_cycles, perf_instret
`endif
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: counts waiting cycles, flags the MEM_TIMEOUT-th consecutive one.
// Latency: expired is combinational on the waiting cycle; clr has priority over en.
module mem_wait_timer #(
   parameter int TMO_W       = 4,
   parameter int MEM_TIMEOUT = 12
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [TMO_W-1:0] LAST = TMO_W'(MEM_TIMEOUT - 1);

   logic [TMO_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + TMO_W'(1);
      end
   end

   assign expired = en && (count == LAST);
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with Moore datapath controls and sticky traps.
// Latency R/I 4, load 5, store 4, branch 3 cycles; stalls on mem_ready. Option: MULTICYCLE_CONTROL_PERF_EN.
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 7,
   parameter int TMO_W       = 4,
   parameter int MEM_TIMEOUT = 12
`ifdef MULTICYCLE_CONTROL_PERF_EN
   , parameter int CNT_W     = 32
`endif
)(
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master bus
);
   state_t              state;
   ctrl_t               ctrl;
   logic [OPCODE_W-1:0] opQ;
   logic                trapQ;
   logic [1:0]          trapCause;
   logic                waiting;
   logic                tmoClr;
   logic                tmoEn;
   logic                tmoExpired;

   assign waiting = (state == S_FETCH) || (state == S_MEM);
   assign tmoEn   = waiting && !bus.mem_ready;
   assign tmoClr  = !waiting || bus.mem_ready;

   mem_wait_timer #(
      .TMO_W       (TMO_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) uTimer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmoClr),
      .en      (tmoEn),
      .expired (tmoExpired)
   );

   // Controls are loaded together with the next state so they are registered Moore outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ctrl      <= '0;
         opQ       <= '0;
         trapQ     <= 1'b0;
         trapCause <= CAUSE_NONE;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.run) begin
                  state <= S_FETCH;
                  ctrl  <= ctrlFor(S_FETCH, opQ);
               end
            end
            S_FETCH: begin
               if (bus.mem_ready) begin
                  state <= S_DECODE;
                  ctrl  <= '0;
               end else if (tmoExpired) begin
                  state     <= S_TRAP;
                  ctrl      <= '0;
                  trapQ     <= 1'b1;
                  trapCause <= CAUSE_MEM_TMO;
               end
            end
            S_DECODE: begin
               opQ <= bus.opcode;
               if (isLegal(bus.opcode)) begin
                  state <= S_EXEC;
                  ctrl  <= ctrlFor(S_EXEC, bus.opcode);
               end else begin
                  state     <= S_TRAP;
                  ctrl      <= '0;
                  trapQ     <= 1'b1;
                  trapCause <= CAUSE_ILLEGAL;
               end
            end
            S_EXEC: begin
               if (opQ == OP_BRANCH) begin
                  state <= S_FETCH;
                  ctrl  <= ctrlFor(S_FETCH, opQ);
               end else if ((opQ == OP_LOAD) || (opQ == OP_STORE)) begin
                  state <= S_MEM;
                  ctrl  <= ctrlFor(S_MEM, opQ);
               end else begin
                  state <= S_WB;
                  ctrl  <= ctrlFor(S_WB, opQ);
               end
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  if (opQ == OP_LOAD) begin
                     state <= S_WB;
                     ctrl  <= ctrlFor(S_WB, opQ);
                  end else begin
                     state <= S_FETCH;
                     ctrl  <= ctrlFor(S_FETCH, opQ);
                  end
               end else if (tmoExpired) begin
                  state     <= S_TRAP;
                  ctrl      <= '0;
                  trapQ     <= 1'b1;
                  trapCause <= CAUSE_MEM_TMO;
               end
            end
            S_WB: begin
               state <= S_FETCH;
               ctrl  <= ctrlFor(S_FETCH, opQ);
            end
            S_TRAP: begin
               ctrl <= '0;
            end
            default: begin
               state <= S_IDLE;
               ctrl  <= '0;
            end
         endcase
      end
   end

   // IR load and PC+4 fire in the cycle the fetch completes, so they follow mem_ready directly.
   assign bus.ir_write      = (state == S_FETCH) && bus.mem_ready;
   assign bus.pc_write      = (state == S_FETCH) && bus.mem_ready;
   assign bus.pc_write_cond = ctrl.pcWriteCond;
   assign bus.mem_read      = ctrl.memRead;
   assign bus.mem_write     = ctrl.memWrite;
   assign bus.i_or_d        = ctrl.iOrD;
   assign bus.alu_src_a     = ctrl.aluSrcA;
   assign bus.alu_src_b     = ctrl.aluSrcB;
   assign bus.alu_op        = ctrl.aluOp;
   assign bus.mem_to_reg    = ctrl.memToReg;
   assign bus.reg_write     = ctrl.regWrite;
   assign bus.state_o       = state;
   assign bus.trap          = trapQ;
   assign bus.trap_cause    = trapCause;

`ifdef MULTICYCLE_CONTROL_PERF_EN
   logic             retire;
   logic [CNT_W-1:0] perfCycles;
   logic [CNT_W-1:0] perfInstret;

   assign retire = (state == S_WB) ||
                   ((state == S_MEM) && bus.mem_ready && (opQ == OP_STORE)) ||
                   ((state == S_EXEC) && (opQ == OP_BRANCH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perfCycles  <= '0;
         perfInstret <= '0;
      end else begin
         if ((state != S_IDLE) && (state != S_TRAP)) begin
            perfCycles <= perfCycles + CNT_W'(1);
         end
         if (retire) begin
            perfInstret <= perfInstret + CNT_W'(1);
         end
      end
   end

   assign bus.perf_cycles  = perfCycles;
   assign bus.perf_instret = perfInstret;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand sequences for traps and reset.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_multicycle_control;

   localparam logic [6:0] R   = 7'b0110011;
   localparam logic [6:0] IA  = 7'b0010011;
   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct packed {
      logic [2:0] st;
      logic       pcW, pcWC, irW, mr, mw, iod, asa;
      logic [1:0] asb, aop;
      logic       m2r, rw, tr;
      logic [1:0] cause;
   } exp_t;

   typedef struct {
      logic       run;
      logic [6:0] op;
      logic       mrdy;
      exp_t       exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   exp_t eIdle, eFetchW, eFetchR, eDec, eExR, eExI, eExLS, eExB;
   exp_t eMemLd, eMemSt, eWbAlu, eWbLd, eTrapIll, eTrapTmo;
   vec_t vecs[$];

   multicycle_control_if bus();

   multicycle_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t sample();
      exp_t g;
      g.st    = bus.state_o;
      g.pcW   = bus.pc_write;
      g.pcWC  = bus.pc_write_cond;
      g.irW   = bus.ir_write;
      g.mr    = bus.mem_read;
      g.mw    = bus.mem_write;
      g.iod   = bus.i_or_d;
      g.asa   = bus.alu_src_a;
      g.asb   = bus.alu_src_b;
      g.aop   = bus.alu_op;
      g.m2r   = bus.mem_to_reg;
      g.rw    = bus.reg_write;
      g.tr    = bus.trap;
      g.cause = bus.trap_cause;
      return g;
   endfunction

   task automatic chk(input string name, input exp_t exp);
      exp_t got;
      got = sample();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d ctl=%b got_all=%b required=%b", name, got.st,
                  got[15:3], got, exp);
      end
   endtask

   task automatic chkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   // Compare this cycle's outputs, then advance to the next falling edge.
   task automatic step(input string name, input exp_t exp);
      #1;
      chk(name, exp);
      @(negedge clk);
   endtask

   task automatic drive(input logic run, input logic [6:0] op, input logic mrdy);
      bus.run       = run;
      bus.opcode    = op;
      bus.mem_ready = mrdy;
   endtask

   task automatic doReset();
      rst = 1'b1;
      drive(1'b0, 7'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic addVec(input logic run, input logic [6:0] op, input logic mrdy, input exp_t exp);
      vec_t v;
      v.run  = run;
      v.op   = op;
      v.mrdy = mrdy;
      v.exp  = exp;
      vecs.push_back(v);
   endtask

   initial begin
      eIdle    = '0;
      eFetchW  = '0; eFetchW.st = 3'd1; eFetchW.mr = 1'b1; eFetchW.asb = 2'b01;
      eFetchR  = eFetchW; eFetchR.pcW = 1'b1; eFetchR.irW = 1'b1;
      eDec     = '0; eDec.st = 3'd2;
      eExR     = '0; eExR.st = 3'd3; eExR.asa = 1'b1; eExR.asb = 2'b00; eExR.aop = 2'b10;
      eExI     = '0; eExI.st = 3'd3; eExI.asa = 1'b1; eExI.asb = 2'b10; eExI.aop = 2'b10;
      eExLS    = '0; eExLS.st = 3'd3; eExLS.asa = 1'b1; eExLS.asb = 2'b10; eExLS.aop = 2'b00;
      eExB     = '0; eExB.st = 3'd3; eExB.asa = 1'b1; eExB.asb = 2'b00; eExB.aop = 2'b01; eExB.pcWC = 1'b1;
      eMemLd   = '0; eMemLd.st = 3'd4; eMemLd.iod = 1'b1; eMemLd.mr = 1'b1;
      eMemSt   = '0; eMemSt.st = 3'd4; eMemSt.iod = 1'b1; eMemSt.mw = 1'b1;
      eWbAlu   = '0; eWbAlu.st = 3'd5; eWbAlu.rw = 1'b1;
      eWbLd    = eWbAlu; eWbLd.m2r = 1'b1;
      eTrapIll = '0; eTrapIll.st = 3'd7; eTrapIll.tr = 1'b1; eTrapIll.cause = 2'b01;
      eTrapTmo = '0; eTrapTmo.st = 3'd7; eTrapTmo.tr = 1'b1; eTrapTmo.cause = 2'b10;

      // R-type zero-wait, then load with three MEM stalls, store, branch, I-ALU.
      addVec(1, R,  1, eIdle);   addVec(1, R,  1, eFetchR); addVec(1, R,  1, eDec);
      addVec(1, R,  1, eExR);    addVec(1, R,  1, eWbAlu);
      addVec(1, LD, 1, eFetchR); addVec(1, LD, 1, eDec);    addVec(1, LD, 0, eExLS);
      addVec(1, LD, 0, eMemLd);  addVec(1, LD, 0, eMemLd);  addVec(1, LD, 0, eMemLd);
      addVec(1, LD, 1, eMemLd);  addVec(1, LD, 1, eWbLd);
      addVec(1, ST, 1, eFetchR); addVec(1, ST, 1, eDec);    addVec(1, ST, 1, eExLS);
      addVec(1, ST, 1, eMemSt);
      addVec(0, BR, 1, eFetchR); addVec(0, BR, 1, eDec);    addVec(0, BR, 1, eExB);
      addVec(0, IA, 1, eFetchR); addVec(0, IA, 1, eDec);    addVec(0, IA, 1, eExI);
      addVec(0, IA, 1, eWbAlu);  addVec(0, R,  1, eFetchR);

      rst = 1'b1;
      drive(1'b1, R, 1'b1);
      #2;
      chk("reset_state", eIdle);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].run, vecs[i].op, vecs[i].mrdy);
         step($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Illegal opcode: sticky trap, run ignored, async reset recovers.
      doReset();
      drive(1'b1, BAD, 1'b1);
      step("ill_idle", eIdle);
      step("ill_fetch", eFetchR);
      step("ill_decode", eDec);
      for (int i = 0; i < 4; i++) begin
         bus.run = i[0];
         step($sformatf("ill_trap%0d", i), eTrapIll);
      end
      #2;
      rst = 1'b1;
      #1;
      chk("ill_async_reset", eIdle);
      @(negedge clk);
      rst = 1'b0;

      // Fetch timeout: 12 waiting cycles then trap cause 10.
      drive(1'b1, R, 1'b0);
      step("tmo_idle", eIdle);
      for (int k = 1; k <= 12; k++) step($sformatf("tmo_wait%0d", k), eFetchW);
      step("tmo_fetch_trap", eTrapTmo);

      // mem_ready on the 12th waiting cycle wins over the timeout.
      doReset();
      drive(1'b1, R, 1'b0);
      step("edge_idle", eIdle);
      for (int k = 1; k <= 11; k++) step($sformatf("edge_wait%0d", k), eFetchW);
      bus.mem_ready = 1'b1;
      step("edge_fetch12", eFetchR);
      step("edge_decode", eDec);

      // Store stuck in MEM times out as well.
      doReset();
      drive(1'b1, ST, 1'b1);
      step("mtmo_idle", eIdle);
      step("mtmo_fetch", eFetchR);
      step("mtmo_decode", eDec);
      bus.mem_ready = 1'b0;
      step("mtmo_exec", eExLS);
      for (int k = 1; k <= 12; k++) step($sformatf("mtmo_wait%0d", k), eMemSt);
      step("mtmo_trap", eTrapTmo);

      // Async reset in the middle of a store access.
      doReset();
      drive(1'b1, ST, 1'b1);
      step("rst_idle", eIdle);
      step("rst_fetch", eFetchR);
      step("rst_decode", eDec);
      bus.mem_ready = 1'b0;
      step("rst_exec", eExLS);
      #1;
      chk("rst_mem_store", eMemSt);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_mem", eIdle);
`ifdef MULTICYCLE_CONTROL_PERF_EN
      chkVal("perf_cycles_reset", bus.perf_cycles, 32'd0);
      chkVal("perf_instret_reset", bus.perf_instret, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

`ifdef MULTICYCLE_CONTROL_PERF_EN
      drive(1'b1, R, 1'b1);
      step("perf_idle", eIdle);
      for (int n = 0; n < 3; n++) begin
         step("perf_fetch", eFetchR);
         step("perf_decode", eDec);
         step("perf_exec", eExR);
         step("perf_wb", eWbAlu);
      end
      #1;
      chkVal("perf_cycles", bus.perf_cycles, 32'd12);
      chkVal("perf_instret", bus.perf_instret, 32'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
